// File: rtl/fp_mult_pkg.sv
// Shared constants and types for the FP32 mantissa multiplier.
package fp_mult_pkg;
  localparam int BIAS   = 127;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 24;
  localparam int PROD_W = 48;

  // FP32 field positions
  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int FRAC_HI  = 22;
  localparam int FRAC_LO  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mult_mantissa_core_if.sv
// Operand/result handshake bundle of the mantissa multiplier.
interface mult_mantissa_core_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [7:0]  out_e;
  logic [47:0] out_m;
  logic        out_zero;
  logic        out_ovf;
  logic        out_unf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_s, out_e, out_m, out_zero, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_s, out_e, out_m, out_zero, out_ovf, out_unf
  );
endinterface

// File: rtl/fp32_unpack.sv
// Splits an FP32 word into sign, exponent and mantissa with hidden one;
// exponent field 0 (zero or denormal) is reported as zero.
module fp32_unpack
  import fp_mult_pkg::*;
(
  input  logic [31:0]      word,
  output logic             f_sign,
  output logic [EXP_W-1:0] f_exp,
  output logic [MAN_W-1:0] f_man,
  output logic             f_zero
);
  assign f_sign = word[SIGN_BIT];
  assign f_exp  = word[EXP_HI:EXP_LO];
  assign f_man  = {1'b1, word[FRAC_HI:FRAC_LO]};
  assign f_zero = (word[EXP_HI:EXP_LO] == '0);
endmodule

// File: rtl/mult_mantissa_core.sv
// Iterative radix-4 FP32 mantissa multiplier: one 2-bit digit of B per
// clock, MSB first, producing a 48-bit product plus pre-normalised exponent.
module mult_mantissa_core #(
  parameter int ITER = 12,
  parameter int BIAS = 127
) (
  input logic                 clk,
  input logic                 rst_n,
  mult_mantissa_core_if.slave bus
);
  import fp_mult_pkg::*;

  logic             a_sign, b_sign, a_zero, b_zero;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;

  fp32_unpack u_unpack_a (.word(bus.in_a), .f_sign(a_sign), .f_exp(a_exp), .f_man(a_man), .f_zero(a_zero));
  fp32_unpack u_unpack_b (.word(bus.in_b), .f_sign(b_sign), .f_exp(b_exp), .f_man(b_man), .f_zero(b_zero));

  state_t              state;
  logic [3:0]          iter_cnt;
  logic                sign_r;
  logic [MAN_W+1:0]    a1x_r, a3x_r;
  logic [MAN_W-1:0]    b_shift_r;
  logic [PROD_W-1:0]   acc_r;
  logic signed [9:0]   exp_sum_r;
  logic [MAN_W+1:0]    pp;
  logic [PROD_W-1:0]   acc_next;
  logic signed [9:0]   exp_fin;

  logic                out_s_r, out_zero_r, out_ovf_r, out_unf_r;
  logic [EXP_W-1:0]    out_e_r;
  logic [PROD_W-1:0]   out_m_r;

  // Bit 47 set means the product is in [2,4): shift right to put the leading one at bit 46.
  function automatic logic [PROD_W-1:0] adjust_mantissa(input logic [PROD_W-1:0] p);
    return p[PROD_W-1] ? (p >> 1) : p;
  endfunction

  function automatic logic signed [9:0] adjust_exponent(input logic signed [9:0] e,
                                                        input logic adj);
    return e + $signed({9'd0, adj});
  endfunction

  wire accept = bus.in_valid && (state == IDLE);

  // Partial product selection from the current top digit of B.
  always_comb begin
    pp = '0;
    case (b_shift_r[MAN_W-1:MAN_W-2])
      2'd0: pp = '0;
      2'd1: pp = a1x_r;
      2'd2: pp = {a1x_r[MAN_W:0], 1'b0};
      2'd3: pp = a3x_r;
      default: pp = '0;
    endcase
  end

  assign acc_next = {acc_r[PROD_W-3:0], 2'b00} + PROD_W'(pp);
  assign exp_fin  = adjust_exponent(exp_sum_r, acc_next[PROD_W-1]);

  // Operand latch at accept and shift-add accumulation during CALC.
  always_ff @(posedge clk) begin
    if (accept) begin
      sign_r    <= a_sign ^ b_sign;
      a1x_r     <= {2'b00, a_man};
      a3x_r     <= {2'b00, a_man} + {1'b0, a_man, 1'b0};
      b_shift_r <= b_man;
      acc_r     <= '0;
      exp_sum_r <= $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - $signed(10'(BIAS));
    end else if (state == CALC) begin
      acc_r     <= acc_next;
      b_shift_r <= {b_shift_r[MAN_W-3:0], 2'b00};
    end
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      iter_cnt   <= '0;
      out_s_r    <= 1'b0;
      out_e_r    <= '0;
      out_m_r    <= '0;
      out_zero_r <= 1'b0;
      out_ovf_r  <= 1'b0;
      out_unf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            iter_cnt <= '0;
            if (a_zero || b_zero) begin
              state      <= DONE;
              out_s_r    <= a_sign ^ b_sign;
              out_e_r    <= '0;
              out_m_r    <= '0;
              out_zero_r <= 1'b1;
              out_ovf_r  <= 1'b0;
              out_unf_r  <= 1'b0;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (iter_cnt == 4'(ITER - 1)) begin
            state      <= DONE;
            out_s_r    <= sign_r;
            out_m_r    <= adjust_mantissa(acc_next);
            out_e_r    <= exp_fin[EXP_W-1:0];
            out_zero_r <= 1'b0;
            out_ovf_r  <= (exp_fin >= 10'sd255);
            out_unf_r  <= (exp_fin <= 10'sd0);
          end else begin
            iter_cnt <= iter_cnt + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_s     = out_s_r;
  assign bus.out_e     = out_e_r;
  assign bus.out_m     = out_m_r;
  assign bus.out_zero  = out_zero_r;
  assign bus.out_ovf   = out_ovf_r;
  assign bus.out_unf   = out_unf_r;
endmodule
